// File: rtl/intr_ctrl_if.sv
// Peripheral register bus shared by the CPU and the interrupt controller:
// select, read/write strobes, write data and a tri-state read-data bus.
interface intr_ctrl_if #(
   parameter int WORD_SIZE = 32
);
   logic [WORD_SIZE-1:0] data;
   logic [1:0]           reg_sel;
   logic                 rd;
   logic                 wr;
   tri   [WORD_SIZE-1:0] out;

   modport master (
      output data,
      output reg_sel,
      output rd,
      output wr,
      input  out
   );

   modport slave (
      input  data,
      input  reg_sel,
      input  rd,
      input  wr,
      output out
   );
endinterface

// File: rtl/intr_ctrl.sv
// Interrupt controller: latches rising edges on the source lines into a
// pending register, masks them with an enable register, and hands the
// lowest-numbered eligible source to the CPU through a claim/complete
// handshake. The irq flop is loaded from next-state values so it tracks
// claims, completes and enable writes on the same edge they happen.
module intr_ctrl #(
   parameter int WORD_SIZE = 32,
   parameter int NUM_SRC   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src,
   intr_ctrl_if.slave         bus,
   output logic               irq
);

   localparam int ID_W = $clog2(NUM_SRC + 1);

   localparam logic [1:0] SEL_PENDING  = 2'd0;
   localparam logic [1:0] SEL_ENABLE   = 2'd1;
   localparam logic [1:0] SEL_CLAIM    = 2'd2;
   localparam logic [1:0] SEL_COMPLETE = 2'd3;

   typedef enum logic {
      IDLE,
      SERVICE
   } state_t;

   state_t             state, next_state;
   logic [NUM_SRC-1:0] pending, next_pending;
   logic [NUM_SRC-1:0] enable, next_enable;
   logic [NUM_SRC-1:0] src_q;
   logic [ID_W-1:0]    in_service, next_in_service;
   logic [ID_W-1:0]    best;
   logic [NUM_SRC-1:0] eligible;
   logic [NUM_SRC-1:0] rise;
   logic               claim_take;
   logic               complete_hit;
   logic [WORD_SIZE-1:0] rd_data;

   assign eligible = pending & enable;
   assign rise     = src & ~src_q;

   // Fixed priority: the lowest index wins, reported as id = index + 1 (0 = none).
   always_comb begin
      best = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            best = ID_W'(i + 1);
         end
      end
   end

   // Next-state logic for the handshake FSM and the pending/enable registers.
   always_comb begin
      next_state      = state;
      next_in_service = in_service;
      next_pending    = pending;
      next_enable     = enable;

      claim_take   = bus.rd && (bus.reg_sel == SEL_CLAIM) && (state == IDLE) && (best != '0);
      complete_hit = bus.wr && (bus.reg_sel == SEL_COMPLETE) && (state == SERVICE) &&
                     (bus.data == WORD_SIZE'(in_service));

      if (claim_take) begin
         next_pending[best - ID_W'(1)] = 1'b0;
         next_in_service               = best;
         next_state                    = SERVICE;
      end

      if (complete_hit) begin
         next_in_service = '0;
         next_state      = IDLE;
      end

      if (bus.wr && (bus.reg_sel == SEL_PENDING)) begin
         next_pending = next_pending & ~bus.data[NUM_SRC-1:0];
      end

      if (bus.wr && (bus.reg_sel == SEL_ENABLE)) begin
         next_enable = bus.data[NUM_SRC-1:0];
      end

      // A new edge beats any clear of the same bit in this cycle.
      next_pending = next_pending | rise;
   end

   // State registers; irq is registered from the next-state values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pending    <= '0;
         enable     <= '0;
         src_q      <= '0;
         in_service <= '0;
         irq        <= 1'b0;
      end else begin
         state      <= next_state;
         pending    <= next_pending;
         enable     <= next_enable;
         src_q      <= src;
         in_service <= next_in_service;
         irq        <= (next_state == IDLE) && (|(next_pending & next_enable));
      end
   end

   // Read-data mux; a CLAIM read in SERVICE repeats the id already in service.
   always_comb begin
      rd_data = '0;
      case (bus.reg_sel)
         SEL_PENDING:  rd_data = WORD_SIZE'(pending);
         SEL_ENABLE:   rd_data = WORD_SIZE'(enable);
         SEL_CLAIM:    rd_data = (state == IDLE) ? WORD_SIZE'(best) : WORD_SIZE'(in_service);
         default:      rd_data = '0;
      endcase
   end

   assign bus.out = bus.rd ? rd_data : 'z;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed testbench for intr_ctrl: reset, edge latching, priority,
// masking, service rules, set-vs-clear collisions and reset mid-service.
module tb_intr_ctrl;

   localparam int WORD_SIZE = 32;
   localparam int NUM_SRC   = 8;

   localparam logic [1:0] PENDING  = 2'd0;
   localparam logic [1:0] ENABLE   = 2'd1;
   localparam logic [1:0] CLAIM    = 2'd2;
   localparam logic [1:0] COMPLETE = 2'd3;

   logic               clk;
   logic               rst;
   logic [NUM_SRC-1:0] src;
   logic               irq;
   int                 errors;
   int                 checks;

   intr_ctrl_if #(.WORD_SIZE(WORD_SIZE)) bus ();

   intr_ctrl #(
      .WORD_SIZE(WORD_SIZE),
      .NUM_SRC  (NUM_SRC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .src(src),
      .bus(bus),
      .irq(irq)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] time limit reached");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reads a register, checks the combinational data, then lets one edge pass with rd high.
   task automatic read_chk(input logic [1:0] sel, input logic [31:0] exp, input string tag);
      bus.reg_sel = sel;
      bus.rd      = 1'b1;
      #1;
      chk(tag, bus.out, exp);
      tick();
      bus.rd = 1'b0;
   endtask

   task automatic write_reg(input logic [1:0] sel, input logic [31:0] val);
      bus.reg_sel = sel;
      bus.data    = val;
      bus.wr      = 1'b1;
      tick();
      bus.wr   = 1'b0;
      bus.data = '0;
   endtask

   initial begin
      errors      = 0;
      checks      = 0;
      rst         = 1'b1;
      src         = '0;
      bus.rd      = 1'b0;
      bus.wr      = 1'b0;
      bus.data    = '0;
      bus.reg_sel = PENDING;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("reset_irq", {31'd0, irq}, 32'd0);
      read_chk(PENDING, 32'h0, "reset_pending");
      read_chk(ENABLE,  32'h0, "reset_enable");
      read_chk(CLAIM,   32'h0, "reset_claim");

      // Basic edge -> irq -> claim -> complete
      write_reg(ENABLE, 32'h01);
      src = 8'h01;
      tick();
      chk("edge_irq", {31'd0, irq}, 32'd1);
      read_chk(PENDING, 32'h01, "edge_pending");
      tick();
      src = 8'h00;
      chk("held_irq", {31'd0, irq}, 32'd1);
      read_chk(CLAIM, 32'd1, "claim1");
      chk("claim1_irq", {31'd0, irq}, 32'd0);
      read_chk(CLAIM, 32'd1, "claim1_repeat");
      read_chk(PENDING, 32'h0, "claim1_pending");
      write_reg(COMPLETE, 32'd1);
      chk("complete1_irq", {31'd0, irq}, 32'd0);
      read_chk(CLAIM, 32'd0, "idle_claim_none");
      read_chk(COMPLETE, 32'd0, "complete_reads_zero");

      // Priority between sources 5 and 2
      write_reg(ENABLE, 32'hFF);
      src = 8'h24;
      tick();
      src = 8'h00;
      chk("prio_irq", {31'd0, irq}, 32'd1);
      read_chk(CLAIM, 32'd3, "prio_claim3");
      chk("prio_irq_drop", {31'd0, irq}, 32'd0);
      write_reg(COMPLETE, 32'd3);
      chk("prio_irq_rerise", {31'd0, irq}, 32'd1);
      read_chk(CLAIM, 32'd6, "prio_claim6");
      write_reg(COMPLETE, 32'd6);
      chk("prio_done_irq", {31'd0, irq}, 32'd0);

      // Masking: disabled source still latches pending
      write_reg(ENABLE, 32'h00);
      src = 8'h10;
      tick();
      src = 8'h00;
      chk("mask_irq", {31'd0, irq}, 32'd0);
      read_chk(PENDING, 32'h10, "mask_pending");
      read_chk(CLAIM, 32'd0, "mask_claim");
      write_reg(ENABLE, 32'h10);
      chk("unmask_irq", {31'd0, irq}, 32'd1);
      read_chk(ENABLE, 32'h10, "enable_readback");
      read_chk(CLAIM, 32'd5, "unmask_claim5");
      write_reg(COMPLETE, 32'd5);
      chk("unmask_done_irq", {31'd0, irq}, 32'd0);

      // Service rules: no nesting, mismatched complete ignored
      write_reg(ENABLE, 32'hFF);
      src = 8'h01;
      tick();
      src = 8'h00;
      read_chk(CLAIM, 32'd1, "svc_claim1");
      src = 8'h02;
      tick();
      src = 8'h00;
      chk("svc_irq_held0", {31'd0, irq}, 32'd0);
      read_chk(PENDING, 32'h02, "svc_pending");
      write_reg(COMPLETE, 32'd2);
      read_chk(CLAIM, 32'd1, "svc_bad_complete");
      chk("svc_bad_complete_irq", {31'd0, irq}, 32'd0);
      write_reg(COMPLETE, 32'd1);
      chk("svc_complete_irq", {31'd0, irq}, 32'd1);
      read_chk(CLAIM, 32'd2, "svc_claim2");
      write_reg(COMPLETE, 32'd2);
      chk("svc_done_irq", {31'd0, irq}, 32'd0);

      // Collision: W1C and new edge on the same bit, set wins
      src = 8'h08;
      tick();
      src = 8'h00;
      tick();
      src = 8'h08;
      write_reg(PENDING, 32'h08);
      src = 8'h00;
      read_chk(PENDING, 32'h08, "w1c_collision");

      // Collision: claim of id 4 and new edge on source 3, set wins
      tick();
      src = 8'h08;
      read_chk(CLAIM, 32'd4, "claim_collision_id");
      src = 8'h00;
      read_chk(PENDING, 32'h08, "claim_collision_pending");
      chk("claim_collision_irq", {31'd0, irq}, 32'd0);
      write_reg(COMPLETE, 32'd4);
      chk("claim_collision_rerise", {31'd0, irq}, 32'd1);
      read_chk(CLAIM, 32'd4, "claim_collision_reclaim");

      // Reset mid-service with source 0 held high
      src = 8'h01;
      rst = 1'b1;
      tick();
      chk("rst_irq", {31'd0, irq}, 32'd0);
      read_chk(PENDING, 32'h0, "rst_pending");
      read_chk(ENABLE,  32'h0, "rst_enable");
      read_chk(CLAIM,   32'h0, "rst_claim");
      rst = 1'b0;
      tick();
      read_chk(PENDING, 32'h01, "post_rst_edge");
      chk("post_rst_irq", {31'd0, irq}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
